// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and constants for the edge event arbiter.
//   MAX_CH              : largest supported channel count
//   EDGE_RISE/EDGE_FALL : encoding of the event type bit
//   arb_state_t         : output FSM state encoding
package edge_arb_pkg;

  localparam int   MAX_CH    = 16;
  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } arb_state_t;

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event stream between the arbiter and its consumer.
//   evt_valid : event presented
//   evt_ready : consumer accepts when high together with evt_valid
//   evt_ch    : channel index of the presented event
//   evt_rise  : 1 = rising edge, 0 = falling edge
// Modports: master (arbiter side), slave (consumer side).
interface edge_event_arbiter_if #(
  parameter int N_CH = 4
);
  localparam int CH_W = $clog2(N_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_rise;

  modport master (output evt_valid, output evt_ch, output evt_rise, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_rise, output evt_ready);

endinterface

// File: rtl/edge_event_arbiter_edge_detect_ch.sv
// One channel of the edge event arbiter: input history flop, enabled edge
// detection, a single-entry pending slot and a sticky overflow flag.
//   clk, reset       : clock, synchronous active-high reset
//   a_i              : synchronized level input
//   rise_en/fall_en  : edge-type enables (combinational into detection)
//   grant            : this channel's pending event is taken this cycle
//   ovf_clr          : overflow clear pulse
//   pend, pend_rise  : pending event and its type
//   ovf              : sticky overflow (an edge was dropped)
module edge_detect_ch
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a_i,
  input  logic rise_en,
  input  logic fall_en,
  input  logic grant,
  input  logic ovf_clr,
  output logic pend,
  output logic pend_rise,
  output logic ovf
);

  logic a_ff_q, a_ff_d;
  logic pend_q, pend_d;
  logic pend_rise_q, pend_rise_d;
  logic ovf_q, ovf_d;
  logic rise, fall, edge_hit, drop;

  always_comb begin
    rise     = ~a_ff_q & a_i & rise_en;
    fall     = a_ff_q & ~a_i & fall_en;
    edge_hit = rise | fall;
    // A slot being granted this cycle is free for a new edge.
    drop     = edge_hit & pend_q & ~grant;

    a_ff_d      = a_i;
    pend_d      = pend_q;
    pend_rise_d = pend_rise_q;
    if (edge_hit && (!pend_q || grant)) begin
      pend_d      = 1'b1;
      pend_rise_d = rise ? EDGE_RISE : EDGE_FALL;
    end else if (grant) begin
      pend_d = 1'b0;
    end

    // Set wins over clear so a same-cycle drop is never lost.
    ovf_d = (ovf_q & ~ovf_clr) | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_ff_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_rise_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      a_ff_q      <= a_ff_d;
      pend_q      <= pend_d;
      pend_rise_q <= pend_rise_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pend      = pend_q;
  assign pend_rise = pend_rise_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge event arbiter: per-channel edge detectors feed a
// round-robin selector that presents one event at a time on a valid/ready
// stream.
//   clk, reset      : clock, synchronous active-high reset
//   a_i             : N_CH synchronized level inputs
//   rise_en/fall_en : per-channel edge enables
//   ovf / ovf_clr   : sticky per-channel overflow and its clear pulse
//   evt             : event stream (master side)
//
// state | meaning
// IDLE  | nothing presented, evt_valid = 0
// VALID | event presented on evt_ch/evt_rise, evt_valid = 1
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         a_i,
  input  logic [N_CH-1:0]         rise_en,
  input  logic [N_CH-1:0]         fall_en,
  output logic [N_CH-1:0]         ovf,
  input  logic [N_CH-1:0]         ovf_clr,
  edge_event_arbiter_if.master    evt
);

  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0] pend, pend_rise, grant;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_detect_ch u_ch (
      .clk       (clk),
      .reset     (reset),
      .a_i       (a_i[g]),
      .rise_en   (rise_en[g]),
      .fall_en   (fall_en[g]),
      .grant     (grant[g]),
      .ovf_clr   (ovf_clr[g]),
      .pend      (pend[g]),
      .pend_rise (pend_rise[g]),
      .ovf       (ovf[g])
    );
  end

  arb_state_t      state_q, state_d;
  logic [CH_W-1:0] last_q, last_d;
  logic [CH_W-1:0] evt_ch_q, evt_ch_d;
  logic            evt_rise_q, evt_rise_d;
  logic            load, any_pend;
  logic [CH_W-1:0] winner;
  int              sel_idx;

  // Round-robin search: first pending channel after the last winner.
  always_comb begin
    any_pend = 1'b0;
    winner   = '0;
    sel_idx  = 0;
    for (int i = 1; i <= N_CH; i++) begin
      sel_idx = (int'(last_q) + i) % N_CH;
      if (!any_pend && pend[sel_idx[CH_W-1:0]]) begin
        any_pend = 1'b1;
        winner   = sel_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    load  = (state_q == IDLE) || evt.evt_ready;
    grant = '0;
    if (load && any_pend) grant[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= CH_W'(N_CH - 1);
      evt_ch_q   <= '0;
      evt_rise_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      evt_ch_q   <= evt_ch_d;
      evt_rise_q <= evt_rise_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    evt_ch_d   = evt_ch_q;
    evt_rise_d = evt_rise_q;
    if (load) begin
      state_d = any_pend ? VALID : IDLE;
      if (any_pend) begin
        last_d     = winner;
        evt_ch_d   = winner;
        evt_rise_d = pend_rise[winner];
      end
    end
  end

  always_comb begin
    evt.evt_valid = (state_q == VALID);
    evt.evt_ch    = evt_ch_q;
    evt.evt_rise  = evt_rise_q;
  end

endmodule
